fir_tap_loader: RTL

//  Run-time coefficient controller for the fir filter. Accepts one frame of

---
 rtl/fir_tap_loader.sv | 115 +++++++++++
 1 files changed

// File: rtl/fir_tap_loader.sv
// Loads one NTAPS-word coefficient frame into a shadow bank and swaps it into the active taps on a sample boundary.
// Latency: earliest swap is the edge after the final word; swap_done/load_err are registered 1-cycle pulses.
// Backpressure: wr_ready drops while a complete frame waits for sample_en; all other states accept every word.
module fir_tap_loader #(
    parameter int NTAPS = 10,
    parameter int WIDTH = 16,
    parameter int GENW  = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         wr_last,
    input  logic                         sample_en,
    output logic [NTAPS-1:0][WIDTH-1:0]  taps,
    output logic                         busy,
    output logic                         swap_done,
    output logic                         load_err,
    output logic [GENW-1:0]              gen
);

    localparam int IDXW = $clog2(NTAPS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        WAIT_SWAP
    } state_t;

    state_t                        state;
    logic [IDXW-1:0]               idx;
    logic [NTAPS-1:0][WIDTH-1:0]   shadow;
    logic                          xfer;

    assign xfer = wr_valid && wr_ready;

    // wr_ready and busy are registered from the next state so they are
    // glitch-free and line up with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            shadow    <= '0;
            taps      <= '0;
            wr_ready  <= 1'b0;
            busy      <= 1'b0;
            swap_done <= 1'b0;
            load_err  <= 1'b0;
            gen       <= '0;
        end else begin
            swap_done <= 1'b0;
            load_err  <= 1'b0;
            case (state)
                IDLE: begin
                    wr_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (xfer) begin
                        shadow[0] <= wr_data;
                        idx       <= IDXW'(1);
                        if (wr_last) begin
                            load_err <= 1'b1;
                        end else begin
                            state <= LOAD;
                            busy  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        shadow[idx] <= wr_data;
                        if (idx != LAST_IDX) begin
                            if (wr_last) begin
                                load_err <= 1'b1;
                                state    <= IDLE;
                                busy     <= 1'b0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else if (wr_last) begin
                            state    <= WAIT_SWAP;
                            wr_ready <= 1'b0;
                        end else begin
                            // Frame too long: swallow the rest up to wr_last.
                            load_err <= 1'b1;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer && wr_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                WAIT_SWAP: begin
                    if (sample_en) begin
                        taps      <= shadow;
                        gen       <= gen + 1'b1;
                        swap_done <= 1'b1;
                        state     <= IDLE;
                        wr_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
